// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified memory port between instruction fetch (if)
// and MEM-stage data (dm) requesters. One transaction is in flight at a time.
// Build option: define ARB_RR_EN to arbitrate simultaneous requests
// round-robin; by default the data port always wins a contention.
module mem_arbiter #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_dm_q, owner_dm_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        if_rdy_q, if_rdy_d;
    logic        dm_rdy_q, dm_rdy_d;
    logic        err_q, err_d;
    logic        grant_dm;
    logic        timeout_hit;
    logic [31:0] resp_data;
`ifdef ARB_RR_EN
    logic        last_dm_q, last_dm_d;
`endif

    // Last BUSY cycle before giving up on the memory.
    assign timeout_hit = (cnt_q == 8'(MEM_TIMEOUT - 1));

    // Grant decision for the current IDLE cycle.
    always_comb begin
`ifdef ARB_RR_EN
        // On contention the port that was not granted last time wins.
        grant_dm = dm_req & (~if_req | ~last_dm_q);
`else
        // Data port wins contention: it belongs to the older instruction.
        grant_dm = dm_req;
`endif
    end

    // Next-state and datapath update for the IDLE/BUSY/RESP sequence.
    always_comb begin
        state_d    = state_q;
        owner_dm_d = owner_dm_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_rdy_d   = 1'b0;
        dm_rdy_d   = 1'b0;
        err_d      = err_q;
        resp_data  = mem_ack ? mem_rdata : 32'h0000_0000;
`ifdef ARB_RR_EN
        last_dm_d  = last_dm_q;
`endif
        case (state_q)
            IDLE: begin
                if (if_req | dm_req) begin
                    state_d    = BUSY;
                    owner_dm_d = grant_dm;
                    addr_d     = grant_dm ? dm_addr : if_addr;
                    we_d       = grant_dm & dm_we;
                    wdata_d    = grant_dm ? dm_wdata : 32'h0000_0000;
                    cnt_d      = 8'd0;
`ifdef ARB_RR_EN
                    last_dm_d  = grant_dm;
`endif
                end
            end
            BUSY: begin
                if (mem_ack | timeout_hit) begin
                    state_d = RESP;
                    cnt_d   = 8'd0;
                    if (!mem_ack) begin
                        err_d = 1'b1;
                    end
                    // A requester that withdrew (flush) gets neither data nor pulse.
                    if (owner_dm_q) begin
                        if (dm_req) begin
                            dm_rdata_d = resp_data;
                            dm_rdy_d   = 1'b1;
                        end
                    end else begin
                        if (if_req) begin
                            if_rdata_d = resp_data;
                            if_rdy_d   = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q    <= IDLE;
            owner_dm_q <= 1'b0;
            addr_q     <= 32'h0000_0000;
            we_q       <= 1'b0;
            wdata_q    <= 32'h0000_0000;
            cnt_q      <= 8'd0;
            if_rdata_q <= 32'h0000_0000;
            dm_rdata_q <= 32'h0000_0000;
            if_rdy_q   <= 1'b0;
            dm_rdy_q   <= 1'b0;
            err_q      <= 1'b0;
`ifdef ARB_RR_EN
            last_dm_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_dm_q <= owner_dm_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_rdy_q   <= if_rdy_d;
            dm_rdy_q   <= dm_rdy_d;
            err_q      <= err_d;
`ifdef ARB_RR_EN
            last_dm_q  <= last_dm_d;
`endif
        end
    end

    // Memory port is only active in BUSY; ready pulses drop if the requester flushes in RESP.
    always_comb begin
        mem_en      = (state_q == BUSY);
        mem_we      = mem_en & we_q;
        mem_addr    = addr_q;
        mem_wdata   = wdata_q;
        if_rdata    = if_rdata_q;
        dm_rdata    = dm_rdata_q;
        if_ready    = if_rdy_q & if_req;
        dm_ready    = dm_rdy_q & dm_req;
        stall_if    = if_req & ~if_ready;
        stall_mem   = dm_req & ~dm_ready;
        err_timeout = err_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// transactions, all predicted by a transaction-level model of the arbiter.
module tb_mem_arbiter;

    localparam int TMO = 6;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        err_timeout;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .err_timeout(err_timeout)
    );

    int n_run  = 0;
    int n_fail = 0;

    // Reference model state
    bit          m_last_dm  = 1'b0;
    logic [31:0] m_if_rdata = 32'h0;
    logic [31:0] m_dm_rdata = 32'h0;
    bit          m_err      = 1'b0;
    logic [31:0] late_addr  = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Which port the arbiter should pick for the given request pair.
    function automatic bit pick_dm(input bit ir, input bit dr);
`ifdef ARB_RR_EN
        if (ir && dr) return !m_last_dm;
`endif
        return dr;
    endfunction

    // One full transaction starting in an IDLE cycle whose requests are already driven.
    // delay: BUSY cycle (0-based) in which the memory acks; >= TMO means never.
    task automatic serve(input int delay, input logic [31:0] rd, input bit drop, input bit late_dm);
        bit          is_dm;
        bit          ewe;
        bit          tmo;
        bit          done;
        logic [31:0] ea;
        logic [31:0] ew;
        logic [31:0] exp_data;
        #1;
        is_dm = pick_dm(if_req, dm_req);
        ea    = is_dm ? dm_addr : if_addr;
        ewe   = is_dm & dm_we;
        ew    = dm_wdata;
        chk("idle_mem_en", mem_en, 0);
        m_last_dm = is_dm;
        tick();
        if (drop) begin
            if (is_dm) dm_req = 1'b0; else if_req = 1'b0;
        end
        if (late_dm) begin
            dm_req  = 1'b1;
            dm_we   = 1'b0;
            dm_addr = late_addr;
        end
        done = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            if (!done) begin
                mem_ack   = (k == delay);
                mem_rdata = (k == delay) ? rd : $urandom;
                #1;
                chk("busy_mem_en", mem_en, 1);
                chk("busy_mem_addr", mem_addr, ea);
                chk("busy_mem_we", mem_we, ewe);
                if (is_dm) chk("busy_mem_wdata", mem_wdata, ew);
                chk("busy_stall_if", stall_if, if_req);
                chk("busy_stall_mem", stall_mem, dm_req);
                chk("busy_if_ready", if_ready, 0);
                chk("busy_dm_ready", dm_ready, 0);
                if (k == delay) done = 1'b1;
                else if (k < TMO - 1) tick();
            end
        end
        tick();
        mem_ack   = 1'b1;   // stray ack in RESP must be ignored
        mem_rdata = 32'hBAD0_BAD0;
        #1;
        tmo = (delay >= TMO);
        if (tmo) m_err = 1'b1;
        exp_data = tmo ? 32'h0 : rd;
        if (!drop) begin
            if (is_dm) m_dm_rdata = exp_data; else m_if_rdata = exp_data;
        end
        chk("resp_mem_en", mem_en, 0);
        chk("resp_if_ready", if_ready, !drop && !is_dm);
        chk("resp_dm_ready", dm_ready, !drop && is_dm);
        chk("resp_if_rdata", if_rdata, m_if_rdata);
        chk("resp_dm_rdata", dm_rdata, m_dm_rdata);
        chk("resp_err_timeout", err_timeout, m_err);
        chk("resp_stall_if", stall_if, if_req && !(!drop && !is_dm));
        chk("resp_stall_mem", stall_mem, dm_req && !(!drop && is_dm));
        if (is_dm) dm_req = 1'b0; else if_req = 1'b0;
        tick();
        mem_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b1; if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = 32'h0; dm_wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        tick();
        tick();
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_dm_ready", dm_ready, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_err", err_timeout, 0);
        rstn = 1'b0;
        tick();

        // Single fetch, ack on first BUSY cycle
        if_req = 1'b1; if_addr = 32'h0000_0004;
        serve(0, 32'h0050_0093, 1'b0, 1'b0);

        // Contention: dm store first, then a second contention against the waiting fetch
        if_req = 1'b1; if_addr = 32'h0000_0200;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0100; dm_wdata = 32'hDEAD_BEEF;
        #1;
        chk("cont1_mem_en_idle", mem_en, 0);
        serve(0, 32'h1111_1111, 1'b0, 1'b0);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0104; dm_wdata = 32'h0BAD_F00D;
        serve(1, 32'h2222_2222, 1'b0, 1'b0);
        serve(0, 32'h3333_3333, 1'b0, 1'b0);

        // Slow memory: ack in fifth BUSY cycle
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0040;
        serve(4, 32'hCAFE_F00D, 1'b0, 1'b0);

        // Timeout, then a normal transaction with the flag still set
        if_req = 1'b1; if_addr = 32'h0000_0008;
        serve(TMO + 2, 32'h7777_7777, 1'b0, 1'b0);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0044;
        serve(1, 32'h1234_5678, 1'b0, 1'b0);

        // Flush: fetch dropped while BUSY, pending dm load granted next
        if_req = 1'b1; if_addr = 32'h0000_000C;
        late_addr = 32'h0000_0048;
        serve(2, 32'hFFFF_0000, 1'b1, 1'b1);
        serve(0, 32'h4444_4444, 1'b0, 1'b0);

        // Reset in the middle of a BUSY store, then a late ack
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0080; dm_wdata = 32'h0000_0055;
        tick();
        chk("rstbusy_mem_en", mem_en, 1);
        rstn = 1'b1;
        tick();
        rstn = 1'b0; dm_req = 1'b0;
        m_if_rdata = 32'h0; m_dm_rdata = 32'h0; m_err = 1'b0; m_last_dm = 1'b0;
        #1;
        chk("rstbusy_mem_en0", mem_en, 0);
        chk("rstbusy_mem_we", mem_we, 0);
        chk("rstbusy_mem_addr", mem_addr, 0);
        chk("rstbusy_mem_wdata", mem_wdata, 0);
        chk("rstbusy_if_rdata", if_rdata, 0);
        chk("rstbusy_dm_rdata", dm_rdata, 0);
        chk("rstbusy_err", err_timeout, 0);
        mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            dm_req = 1'b1;
            #1;
            chk("lateack_dm_ready", dm_ready, 0);
            chk("lateack_mem_en", mem_en, 0);
            dm_req = 1'b0;
        end
        mem_ack = 1'b0;
        tick();

        // Random traffic
        for (int r = 0; r < 40; r++) begin
            if_req  = 1'($urandom_range(0, 1));
            dm_req  = 1'($urandom_range(0, 1));
            if (!if_req && !dm_req) if_req = 1'b1;
            if_addr = {$urandom_range(0, 65535), 2'b00} ;
            dm_addr = $urandom;
            dm_we   = 1'($urandom_range(0, 1));
            dm_wdata = $urandom;
            while (if_req || dm_req) begin
                serve(($urandom_range(0, 7) == 0) ? TMO + 1 : int'($urandom_range(0, 4)),
                      $urandom, ($urandom_range(0, 7) == 0), 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: cycles to wait for mem_ack before aborting a transaction, legal range 1..255.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn, input, 1: synchronous, active-high reset (1 = reset asserted).
REQ-004 SHALL have port if_req, input, 1: instruction fetch request, held high with if_addr stable until if_ready.
REQ-005 SHALL have port if_addr, input, 32: fetch address.
REQ-006 SHALL have ports if_rdata (output, 32) and if_ready (output, 1): fetched word and its one-cycle valid pulse.
REQ-007 SHALL have ports dm_req (input, 1), dm_we (input, 1), dm_addr (input, 32), dm_wdata (input, 32): MEM-stage data request, held stable until dm_ready.
REQ-008 SHALL have ports dm_rdata (output, 32) and dm_ready (output, 1): load data and completion pulse; the pulse also completes stores.
REQ-009 SHALL have ports mem_en (output, 1), mem_we (output, 1), mem_addr (output, 32), mem_wdata (output, 32): unified memory request.
REQ-010 SHALL have ports mem_rdata (input, 32) and mem_ack (input, 1): memory data, sampled when mem_ack is high.
REQ-011 SHALL have ports stall_if, stall_mem, err_timeout (output, 1 each): pipeline stall requests and sticky timeout flag.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-013 IDLE SHALL sample if_req and dm_req; if either is high, it latches the winner's addr, we and wdata, records the owner, and goes to BUSY on the next edge.
REQ-014 Fixed priority SHALL apply when both requests are high: dm wins, because the older instruction goes first.
REQ-015 BUSY SHALL hold mem_en=1 and drive the latched mem_addr, mem_we and mem_wdata; mem_we SHALL be 0 for if transactions.
REQ-016 In BUSY with mem_ack=1, the arbiter SHALL register mem_rdata into the owner's rdata and go to RESP.
REQ-017 mem_ack SHALL be ignored outside BUSY.
REQ-018 RESP SHALL pulse the owner's ready for exactly one cycle, then return to IDLE; requests are not sampled in RESP.
REQ-019 Minimum latency SHALL be 3 cycles: request seen in IDLE at cycle 0, mem_en high in cycle 1 with mem_ack=1 in the same cycle, ready high in cycle 2.
REQ-020 A BUSY cycle counter SHALL start at 0; if it reaches MEM_TIMEOUT without mem_ack, the arbiter sets err_timeout, sets the owner's rdata to 0x00000000 and goes to RESP.
REQ-021 err_timeout SHALL stay set until reset.
REQ-022 Dropped request: if the owner's req is low in RESP (pipeline flush), the arbiter SHALL suppress the ready pulse and discard the data; the memory transaction is still completed.
REQ-023 stall_if SHALL equal if_req & ~if_ready, and stall_mem SHALL equal dm_req & ~dm_ready; both are combinational from registered state.
REQ-024 if_rdata and dm_rdata SHALL hold their last value until overwritten by a new completion of their own port.
REQ-025 The memory SHALL never see two outstanding transactions; mem_en SHALL be low in IDLE and RESP.

Reset
REQ-026 On rstn=1 at a clock edge: state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ready=0, dm_ready=0, if_rdata=0, dm_rdata=0, err_timeout=0, counter=0, last-grant=if.
REQ-027 A reset asserted in BUSY or RESP SHALL abort the transaction with no ready pulse; a mem_ack arriving after reset is ignored.

Configuration
REQ-028 Macro ARB_RR_EN: when defined, simultaneous if_req and dm_req SHALL be granted round-robin (the port not granted last wins, and the last-grant register updates on each grant); when undefined, REQ-014 fixed dm priority applies and the last-grant register is absent.

Verification
REQ-029 Single fetch: if_req=1, if_addr=0x00000004, mem_ack on first BUSY cycle with mem_rdata=0x00500093 -> mem_en high 1 cycle, if_ready pulse in cycle 2, if_rdata=0x00500093.
REQ-030 Contention: if_req=dm_req=1 together, dm store addr 0x100, wdata 0xDEADBEEF -> dm served first with mem_we=1, then if; without ARB_RR_EN repeat -> dm first again; with ARB_RR_EN -> if first on the second contention.
REQ-031 Slow memory: mem_ack delayed 5 cycles -> mem_en high 5 cycles, stall_mem high throughout, dm_ready one pulse, err_timeout=0.
REQ-032 Timeout: MEM_TIMEOUT=4, no mem_ack -> err_timeout=1 after 4 BUSY cycles, if_rdata=0, if_ready pulse; err_timeout stays 1 on later transactions.
REQ-033 Flush: if_req dropped while BUSY -> no if_ready pulse, if_rdata unchanged, next IDLE grants pending dm_req.
REQ-034 Reset mid-BUSY: rstn=1 for 1 cycle -> all outputs zero, state IDLE, late mem_ack produces no ready pulse.
